alu_wb_stage: RTL and testbench
===============================

ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered result entries (legal values 2 or 4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  ALU result present this cycle.
REQ-005 SHALL have port in_ready  output  1  stage can accept a result.
REQ-006 SHALL have port in_op  input  4  ALUOp code that produced the result.
REQ-007 SHALL have port in_result  input  32  ALU Result.
REQ-008 SHALL have port in_flags  input  4  ALU flags {Negative, Zero, Carry, Overflow}.
REQ-009 SHALL have port out_valid  output  1  head entry available.
REQ-010 SHALL have port out_ready  input  1  consumer takes head entry.
REQ-011 SHALL have port out_result  output  32  head entry result.
REQ-012 SHALL have port out_flags  output  4  head entry NZCV status snapshot.
REQ-013 SHALL have port clr_sticky  input  1  clears sticky_ovf.
REQ-014 SHALL have port sticky_ovf  output  1  overflow has occurred since last clear.
REQ-015 SHALL have port op_count  output  16  number of accepted results.

Function
REQ-016 SHALL accept an input on a rising edge where in_valid=1 and in_ready=1; SHALL push nothing otherwise.
REQ-017 SHALL drive in_ready=1 iff buffer occupancy < DEPTH; no push-through when full, even if out_ready=1 in that cycle.
REQ-018 SHALL pop the head on a rising edge where out_valid=1 and out_ready=1.
REQ-019 SHALL handle simultaneous push and pop when not full or empty: occupancy unchanged, FIFO order preserved.
REQ-020 SHALL have a latency of 1 cycle: a result accepted at edge t is visible at the outputs after edge t when the buffer was empty; results SHALL never bypass combinationally.
REQ-021 SHALL drive out_valid=1 iff occupancy > 0; out_result=0 and out_flags=0 when empty.
REQ-022 SHALL keep an internal NZCV status register, updated on each accepted input.
REQ-023 SHALL update N and Z from in_flags for every op code.
REQ-024 SHALL update C and V from in_flags only for in_op 4'b0000 (ADD) and 4'b0001 (SUB); for all other codes (0010-1111, including unused 1010-1111) C and V SHALL hold.
REQ-025 SHALL store the post-update NZCV value with the entry; out_flags SHALL present that snapshot.
REQ-026 SHALL set sticky_ovf on an accepted ADD/SUB with in_flags Overflow=1; clr_sticky=1 clears it; set wins on the same edge.
REQ-027 SHALL increment op_count by 1 per accepted input, wrapping 16'hFFFF -> 16'h0000.
REQ-028 SHALL implement pointers modulo DEPTH with wrap-around; occupancy held in an explicit counter 0..DEPTH.

Reset
REQ-029 SHALL on rst=1 at a rising edge: occupancy=0, pointers=0, NZCV=0, sticky_ovf=0, op_count=0; out_valid=0, out_result=0, out_flags=0, in_ready=1 after that edge.
REQ-030 SHALL take priority for rst over any simultaneous push, pop, or clr_sticky; buffered entries are discarded mid-operation.
REQ-031 SHALL drive in_ready=0 while rst=1.

Verification
REQ-032 SHALL be verified with: ADD op 0000, result 15, flags 0000, out_ready=1 -> next cycle out_valid=1, out_result=15, out_flags=0000, op_count=1.
REQ-033 SHALL be verified with: ADD result 0x80000000, flags N=1,V=1 (1001), then AND op 0010, result 0x0F000F00, flags 0000 -> second entry out_flags=0001 (C,V held), sticky_ovf=1.
REQ-034 SHALL be verified with: SUB op 0001, result 0, flags Z=1,C=1 (0110) -> out_flags=0110; then clr_sticky and an overflowing SUB on the same edge -> sticky_ovf stays 1.
REQ-035 SHALL be verified with: out_ready=0, DEPTH=2, three back-to-back valid inputs -> first two accepted, in_ready=0 on the third, which is held; release out_ready -> order 1,2,3 preserved.
REQ-036 SHALL be verified with: buffer holding 1 entry, simultaneous push and pop for 5 cycles -> occupancy stays 1, pointer wrap exercised, no loss or duplication.
REQ-037 SHALL be verified with: rst asserted with 2 entries buffered -> out_valid=0, op_count=0, sticky_ovf=0 after the edge; an op_count wrap check preloads 65535 accepts -> next accept gives 0.

Source files
------------

// File: rtl/alu_wb_stage.sv
// rtl/alu_wb_stage.sv - ALU write-back stage: result FIFO with NZCV snapshot, sticky overflow and op counter
//
// Buffers ALU results in a DEPTH-entry FIFO (DEPTH = 2 or 4). Each accepted
// result updates an internal NZCV register; the post-update value is stored
// alongside the result so the consumer sees the status as of that op.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      producer handshake
//   in_op, in_result,      ALUOp code, 32-bit result, flags {N,Z,C,V}
//   in_flags
//   out_valid/out_ready    consumer handshake on the head entry
//   out_result, out_flags  head entry result and NZCV snapshot (0 when empty)
//   clr_sticky, sticky_ovf clear / status of the sticky overflow bit
//   op_count               count of accepted results, wraps at 16 bits
module alu_wb_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_result,
  input  logic [3:0]  in_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags,
  input  logic        clr_sticky,
  output logic        sticky_ovf,
  output logic [15:0] op_count
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;

  logic [31:0]   res_mem [DEPTH];
  logic [3:0]    flg_mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic [3:0]    nzcv;
  logic [3:0]    nzcv_next;
  logic          arith;
  logic          push;
  logic          pop;

  // Only ADD/SUB produce meaningful carry/overflow; every other code,
  // including the unused ones, leaves C and V untouched.
  always_comb begin
    arith     = (in_op == OP_ADD) || (in_op == OP_SUB);
    nzcv_next = {in_flags[3:2], arith ? in_flags[1:0] : nzcv[1:0]};
  end

  // in_ready looks only at occupancy, never at out_ready, so a full
  // buffer refuses input even in a cycle where the head is popped.
  assign in_ready   = !rst && (count != FULL);
  assign out_valid  = (count != '0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign out_result = out_valid ? res_mem[rptr] : 32'h0;
  assign out_flags  = out_valid ? flg_mem[rptr] : 4'h0;

  always_ff @(posedge clk) begin
    if (push) begin
      res_mem[wptr] <= in_result;
      flg_mem[wptr] <= nzcv_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
      end
      if (pop) begin
        rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nzcv     <= 4'h0;
      op_count <= 16'h0;
    end else if (push) begin
      nzcv     <= nzcv_next;
      op_count <= op_count + 16'h1;
    end
  end

  // A new overflow on the same edge as clr_sticky keeps the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf <= 1'b0;
    end else if (push && arith && in_flags[0]) begin
      sticky_ovf <= 1'b1;
    end else if (clr_sticky) begin
      sticky_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// tb/tb_alu_wb_stage.sv - self-checking bench for alu_wb_stage
module tb_alu_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_result;
  logic [3:0]  in_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic        clr_sticky;
  logic        sticky_ovf;
  logic [15:0] op_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] res;
    logic [3:0]  flags;
    logic        clr;
    logic [3:0]  ef;
    logic        es;
  } vec_t;

  vec_t vt [12];

  alu_wb_stage #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_result  (in_result),
    .in_flags   (in_flags),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .clr_sticky (clr_sticky),
    .sticky_ovf (sticky_ovf),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    //          op       result        flags  clr  exp_flags sticky
    vt[0]  = {4'b0000, 32'd15,        4'b0000, 1'b0, 4'b0000, 1'b0};
    vt[1]  = {4'b0000, 32'h80000000,  4'b1001, 1'b0, 4'b1001, 1'b1};
    vt[2]  = {4'b0010, 32'h0F000F00,  4'b0000, 1'b0, 4'b0001, 1'b1};
    vt[3]  = {4'b0001, 32'h00000000,  4'b0110, 1'b0, 4'b0110, 1'b1};
    vt[4]  = {4'b1010, 32'h0000DEAD,  4'b1111, 1'b0, 4'b1110, 1'b1};
    vt[5]  = {4'b1111, 32'h12345678,  4'b0000, 1'b0, 4'b0010, 1'b1};
    vt[6]  = {4'b0001, 32'h00000007,  4'b0001, 1'b1, 4'b0001, 1'b1};
    vt[7]  = {4'b0011, 32'hA5A5A5A5,  4'b0000, 1'b1, 4'b0001, 1'b0};
    vt[8]  = {4'b0000, 32'hFFFFFFFF,  4'b0011, 1'b1, 4'b0011, 1'b1};
    vt[9]  = {4'b0101, 32'h00000000,  4'b0101, 1'b0, 4'b0111, 1'b1};
    vt[10] = {4'b0100, 32'h80000001,  4'b1000, 1'b1, 4'b1011, 1'b0};
    vt[11] = {4'b0000, 32'h80000002,  4'b1000, 1'b0, 4'b1000, 1'b0};

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_op      = 4'h0;
    in_result  = 32'h0;
    in_flags   = 4'h0;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    tick();
    chk("in_ready_during_rst", in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_flags", out_flags, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sticky", sticky_ovf, 0);
    chk("rst_op_count", op_count, 0);

    // Directed vectors, one accept per cycle with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid   = 1'b1;
      in_op      = vt[i].op;
      in_result  = vt[i].res;
      in_flags   = vt[i].flags;
      clr_sticky = vt[i].clr;
      tick();
      chk($sformatf("v%0d_out_valid", i), out_valid, 1);
      chk($sformatf("v%0d_out_result", i), out_result, vt[i].res);
      chk($sformatf("v%0d_out_flags", i), out_flags, vt[i].ef);
      chk($sformatf("v%0d_sticky", i), sticky_ovf, vt[i].es);
      chk($sformatf("v%0d_op_count", i), op_count, i + 1);
    end
    exp_cnt    = 12;
    in_valid   = 1'b0;
    clr_sticky = 1'b0;
    tick();
    chk("drain_out_valid", out_valid, 0);
    chk("drain_out_result", out_result, 0);
    chk("drain_out_flags", out_flags, 0);

    // Full buffer: third input is held, no push-through while full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 4'b0010;
    in_flags  = 4'b0000;
    in_result = 32'h111;
    tick();
    in_result = 32'h222;
    tick();
    in_result = 32'h333;
    chk("full_in_ready", in_ready, 0);
    chk("full_head", out_result, 32'h111);
    tick();
    chk("full_held_count", op_count, exp_cnt + 2);
    chk("full_held_head", out_result, 32'h111);
    out_ready = 1'b1;
    chk("full_pop_in_ready", in_ready, 0);
    tick();
    chk("full_no_pushthru_count", op_count, exp_cnt + 2);
    chk("order_2", out_result, 32'h222);
    chk("after_pop_in_ready", in_ready, 1);
    tick();
    chk("order_3", out_result, 32'h333);
    chk("third_accept_count", op_count, exp_cnt + 3);
    exp_cnt  = exp_cnt + 3;
    in_valid = 1'b0;
    tick();
    chk("full_drain_valid", out_valid, 0);

    // One entry resident, simultaneous push and pop for five cycles.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_result = 32'h200;
    tick();
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      in_result = 32'h200 + k;
      tick();
      chk($sformatf("pp%0d_valid", k), out_valid, 1);
      chk($sformatf("pp%0d_head", k), out_result, 32'h200 + k);
      chk($sformatf("pp%0d_in_ready", k), in_ready, 1);
    end
    exp_cnt  = exp_cnt + 6;
    in_valid = 1'b0;
    tick();
    chk("pp_empty", out_valid, 0);
    chk("pp_count", op_count, exp_cnt);

    // Reset with two buffered entries and sticky set.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 4'b0000;
    in_flags  = 4'b0001;
    in_result = 32'h300;
    tick();
    in_result = 32'h301;
    tick();
    chk("pre_rst_sticky", sticky_ovf, 1);
    chk("pre_rst_valid", out_valid, 1);
    rst       = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready_low", in_ready, 0);
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_result", out_result, 0);
    chk("mid_rst_op_count", op_count, 0);
    chk("mid_rst_sticky", sticky_ovf, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    in_valid  = 1'b1;
    in_op     = 4'b0010;
    in_flags  = 4'b0100;
    in_result = 32'h400;
    tick();
    chk("nzcv_cleared", out_flags, 4'b0100);

    // op_count wrap: already 1 accept, run to 65535 then one more.
    for (int n = 1; n < 65535; n++) begin
      tick();
    end
    chk("cnt_ffff", op_count, 32'hFFFF);
    tick();
    chk("cnt_wrap", op_count, 0);
    in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
